// File: rtl/seq_sum_accumulator_pkg.sv
// Shared types and helpers for the batch accumulator that sits behind the adder.
package seq_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Sample counter width; a single-sample batch still gets a 1-bit counter.
  function automatic int cnt_w(input int count);
    int w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_sum_accumulator_if.sv
// Input-sample and batch-result handshakes between the adder, the accumulator and its consumer.
interface seq_sum_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/seq_sum_accumulator_add_carry.sv
// Accumulator adder: ACC_W-bit running sum plus a zero-extended operand, with carry-out.
module acc_add_carry #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [WIDTH-1:0] i_opd,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + (ACC_W+1)'(i_opd);
  assign o_sum   = w_full[ACC_W-1:0];
  assign o_carry = w_full[ACC_W];

endmodule

// File: rtl/seq_sum_accumulator.sv
// Sums COUNT accepted samples into one batch total with a sticky overflow flag.
// State | meaning: ACCUM | taking samples ; HOLD | result valid, waiting for consumer
module seq_sum_accumulator
  import seq_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int ACC_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_sum_accumulator_if.slave   bus
);

  localparam int              CNT_W    = cnt_w(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_sticky;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  assign w_in_ready = (r_state == ACCUM);
  assign w_accept   = bus.in_valid && w_in_ready;

  acc_add_carry #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_add (
    .i_acc   (r_acc),
    .i_opd   (bus.in_data),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCUM;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf_sticky <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sum    <= '0;
      r_out_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (r_cnt == CNT_LAST) begin
              r_out_sum    <= w_sum;
              r_out_ovf    <= r_ovf_sticky | w_carry;
              r_out_valid  <= 1'b1;
              r_acc        <= '0;
              r_cnt        <= '0;
              r_ovf_sticky <= 1'b0;
              r_state      <= HOLD;
            end else begin
              r_acc        <= w_sum;
              r_ovf_sticky <= r_ovf_sticky | w_carry;
              r_cnt        <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // No bypass: the slot freed here is only usable from the next cycle.
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;

endmodule
